// File: rtl/ofm_buf_pkg.sv
// Shared types and helpers for the ping-pong OFM buffer: FSM states, lane slicing
// and the saturating accumulate used on every lane.
package ofm_buf_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACC_WB = 1'b1
  } state_e;

  localparam int unsigned NUM_BANKS = 2;
  localparam int unsigned MAX_DW    = 32;

  // LSB of lane `lane` inside a packed NUM_CH*dw bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
    return lane * dw;
  endfunction

  // Signed add of two dw-bit values (sign-extended to MAX_DW), clamped to the dw-bit range.
  function automatic logic signed [MAX_DW-1:0] sat_add(input logic signed [MAX_DW-1:0] a,
                                                       input logic signed [MAX_DW-1:0] b,
                                                       input int unsigned              dw);
    logic signed [MAX_DW:0] sum;
    logic signed [MAX_DW:0] hi;
    logic signed [MAX_DW:0] lo;
    sum = (MAX_DW+1)'(a) + (MAX_DW+1)'(b);
    hi  = ((MAX_DW+1)'(1) <<< (dw - 1)) - (MAX_DW+1)'(1);
    lo  = -hi - (MAX_DW+1)'(1);
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return MAX_DW'(sum);
  endfunction

endpackage

// File: rtl/ofm_bank.sv
// One single-port SRAM bank: one read or one write per cycle, read data registered
// one cycle after a read and held otherwise.
module ofm_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_BITS  = 11,
  parameter int unsigned DEPTH      = 2048
) (
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  if (DATA_WIDTH == 8 && DEPTH == 2048) begin : g_st_sphdl_2048x8m8
    // Pin-level view of ST_SPHDL_2048x8m8_L (active-low CSN/WEN); the memory flow binds the macro here.
    logic                  csn;
    logic                  wen;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign csn = ~cs;
    assign wen = ~we;

    always_ff @(posedge clk) begin
      if (!csn) begin
        if (!wen) begin
          mem[11'(addr)] <= wdata;
        end else begin
          rdata <= mem[11'(addr)];
        end
      end
    end
  end else begin : g_behav
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (cs) begin
        if (we) begin
          mem[addr] <= wdata;
        end else begin
          rdata <= mem[addr];
        end
      end
    end
  end

endmodule

// File: rtl/ofm_pingpong_buffer.sv
// NUM_CH-lane ping-pong OFM buffer: compute side overwrites or saturating-accumulates
// into the fill bank while the drain side reads the other bank.
module ofm_pingpong_buffer
  import ofm_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_BITS  = 11,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned NUM_CH     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic                         wr_acc,
  input  logic [ADDR_BITS-1:0]         wr_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
  input  logic                         rd_en,
  input  logic [ADDR_BITS-1:0]         rd_addr,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  output logic                         rd_valid,
  input  logic                         swap_req,
  output logic                         swap_ack,
  output logic                         fill_sel,
  output logic                         busy
);

  localparam int unsigned BUS_W = NUM_CH * DATA_WIDTH;

  state_e               state_q,    state_d;
  logic [ADDR_BITS-1:0] acc_addr_q, acc_addr_d;
  logic [BUS_W-1:0]     acc_data_q, acc_data_d;
  logic [BUS_W-1:0]     rd_hold_q,  rd_hold_d;
  logic                 fill_sel_q, fill_sel_d;
  logic                 wr_ready_q, wr_ready_d;
  logic                 busy_q,     busy_d;
  logic                 swap_ack_q, swap_ack_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_bank_q,  rd_bank_d;
  logic                 rd_oob_q,   rd_oob_d;

  logic                 wr_fire_c;
  logic                 wr_in_range_c;
  logic                 rd_in_range_c;
  logic                 fill_cs_c;
  logic                 fill_we_c;
  logic [ADDR_BITS-1:0] fill_addr_c;
  logic [BUS_W-1:0]     rd_data_c;

  logic                  bank_cs    [NUM_BANKS];
  logic                  bank_we    [NUM_BANKS];
  logic [ADDR_BITS-1:0]  bank_addr  [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS][NUM_CH];
  logic [DATA_WIDTH-1:0] sum_lane   [NUM_CH];
  logic [DATA_WIDTH-1:0] fill_wdata [NUM_CH];

  assign wr_in_range_c = {1'b0, wr_addr} < (ADDR_BITS+1)'(DEPTH);
  assign rd_in_range_c = {1'b0, rd_addr} < (ADDR_BITS+1)'(DEPTH);

  always_comb begin : fsm_next
    state_d     = state_q;
    acc_addr_d  = acc_addr_q;
    acc_data_d  = acc_data_q;
    fill_sel_d  = fill_sel_q;
    swap_ack_d  = 1'b0;
    fill_cs_c   = 1'b0;
    fill_we_c   = 1'b0;
    fill_addr_c = wr_addr;
    wr_fire_c   = wr_valid && wr_ready_q;

    case (state_q)
      IDLE: begin
        // An accepted handshake always wins over a pending swap.
        if (wr_fire_c) begin
          if (wr_in_range_c) begin
            fill_cs_c = 1'b1;
            if (wr_acc) begin
              acc_addr_d = wr_addr;
              acc_data_d = wr_data;
              state_d    = ACC_WB;
            end else begin
              fill_we_c = 1'b1;
            end
          end
        end else if (swap_req) begin
          fill_sel_d = ~fill_sel_q;
          swap_ack_d = 1'b1;
        end
      end
      ACC_WB: begin
        fill_cs_c   = 1'b1;
        fill_we_c   = 1'b1;
        fill_addr_c = acc_addr_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wr_ready_d = (state_d == IDLE);
    busy_d     = (state_d == ACC_WB);
    rd_valid_d = rd_en;
    rd_bank_d  = ~fill_sel_q;
    rd_oob_d   = ~rd_in_range_c;
    rd_hold_d  = rd_data_c;
  end

  // Steer each bank to the compute or drain side; reset blocks every SRAM access.
  always_comb begin : bank_mux
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (fill_sel_q == 1'(b)) begin
        bank_cs[b]   = fill_cs_c && !rst;
        bank_we[b]   = fill_we_c;
        bank_addr[b] = fill_addr_c;
      end else begin
        bank_cs[b]   = rd_en && rd_in_range_c && !rst;
        bank_we[b]   = 1'b0;
        bank_addr[b] = rd_addr;
      end
    end
  end

  always_comb begin : lane_data
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sum_lane[c] = DATA_WIDTH'(sat_add(
          MAX_DW'(signed'(bank_rdata[fill_sel_q][c])),
          MAX_DW'(signed'(acc_data_q[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH])),
          DATA_WIDTH));
      fill_wdata[c] = (state_q == ACC_WB) ? sum_lane[c]
                                          : wr_data[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  // Drain output follows the bank read for one cycle, otherwise holds the last value.
  always_comb begin : rd_mux
    rd_data_c = rd_hold_q;
    if (rd_valid_q) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        rd_data_c[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH] =
            rd_oob_q ? '0 : bank_rdata[rd_bank_q][c];
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      ofm_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS),
        .DEPTH      (DEPTH)
      ) u_bank (
        .clk   (clk),
        .cs    (bank_cs[b]),
        .we    (bank_we[b]),
        .addr  (bank_addr[b]),
        .wdata (fill_wdata[c]),
        .rdata (bank_rdata[b][c])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_addr_q <= '0;
      acc_data_q <= '0;
      rd_hold_q  <= '0;
      fill_sel_q <= 1'b0;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      swap_ack_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_oob_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_addr_q <= acc_addr_d;
      acc_data_q <= acc_data_d;
      rd_hold_q  <= rd_hold_d;
      fill_sel_q <= fill_sel_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      swap_ack_q <= swap_ack_d;
      rd_valid_q <= rd_valid_d;
      rd_bank_q  <= rd_bank_d;
      rd_oob_q   <= rd_oob_d;
    end
  end

  assign wr_ready = wr_ready_q;
  assign busy     = busy_q;
  assign swap_ack = swap_ack_q;
  assign fill_sel = fill_sel_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_c;

endmodule

// File: tb/tb_ofm_pingpong_buffer.sv
// Directed bench for ofm_pingpong_buffer; drain reads are scored against a queue of
// expected words filled when each read is issued.
module tb_ofm_pingpong_buffer;

  localparam int unsigned DW    = 8;
  localparam int unsigned AB    = 11;
  localparam int unsigned DEPTH = 2048;
  localparam int unsigned NCH   = 2;
  localparam int unsigned BW    = NCH * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic          wr_acc;
  logic [AB-1:0] wr_addr;
  logic [BW-1:0] wr_data;
  logic          rd_en;
  logic [AB-1:0] rd_addr;
  logic [BW-1:0] rd_data;
  logic          rd_valid;
  logic          swap_req;
  logic          swap_ack;
  logic          fill_sel;
  logic          busy;

  int            errors = 0;
  int            checks = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] mon_exp;

  always #5 clk = ~clk;

  ofm_pingpong_buffer #(
    .DATA_WIDTH (DW),
    .ADDR_BITS  (AB),
    .DEPTH      (DEPTH),
    .NUM_CH     (NCH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_acc   (wr_acc),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .swap_req (swap_req),
    .swap_ack (swap_ack),
    .fill_sel (fill_sel),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AB-1:0] a, input logic [BW-1:0] d);
    wr_valid = 1'b1;
    wr_acc   = 1'b0;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
    chk1("ovw_wr_ready", wr_ready, 1'b1);
  endtask

  // Request stays asserted through the writeback cycle; it must not be taken twice.
  task automatic acc(input logic [AB-1:0] a, input logic [BW-1:0] d);
    wr_valid = 1'b1;
    wr_acc   = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    chk1("acc_wb_wr_ready", wr_ready, 1'b0);
    chk1("acc_wb_busy", busy, 1'b1);
    step();
    wr_valid = 1'b0;
    wr_acc   = 1'b0;
    chk1("acc_done_busy", busy, 1'b0);
    chk1("acc_done_wr_ready", wr_ready, 1'b1);
  endtask

  task automatic rd(input logic [AB-1:0] a, input logic [BW-1:0] e);
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back(e);
    step();
    rd_en   = 1'b0;
  endtask

  task automatic swap(input logic exp_fill);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk1("swap_ack", swap_ack, 1'b1);
    chk1("swap_fill_sel", fill_sel, exp_fill);
  endtask

  function automatic logic [BW-1:0] pat_a(input int i);
    return {8'(i * 3 + 1), 8'(i ^ 'h5A)};
  endfunction

  function automatic logic [BW-1:0] pat_b(input int i);
    return {8'(240 - i), 8'(i * 7)};
  endfunction

  // Scoreboard: every rd_valid cycle consumes the oldest expected word.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk1("rd_valid_unexpected", rd_valid, 1'b0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rd_data", rd_data, mon_exp);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_acc   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    swap_req = 1'b0;
    step();
    step();
    chk1("rst_fill_sel", fill_sel, 1'b0);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk1("rst_swap_ack", swap_ack, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_rd_data", rd_data, 16'h0000);
    rst = 1'b0;

    // Overwrite, swap, drain; also the last address of the bank.
    wr(11'd5, 16'h3412);
    wr(11'd2047, 16'hA55A);
    swap(1'b1);
    rd(11'd5, 16'h3412);
    chk1("swap_ack_single_pulse", swap_ack, 1'b0);
    rd(11'd2047, 16'hA55A);
    step();
    chk1("rd_valid_idle", rd_valid, 1'b0);
    chk("rd_data_hold", rd_data, 16'hA55A);

    // 10 + 20 + 20 back-to-back into bank 1.
    wr(11'd0, 16'h0A0A);
    acc(11'd0, 16'h1414);
    acc(11'd0, 16'h1414);
    swap(1'b0);
    rd(11'd0, 16'h3232);

    // Saturation: lane0 100+60 -> 127, lane1 -100-60 -> -128.
    wr(11'd7, 16'h9C64);
    acc(11'd7, 16'hC43C);
    swap(1'b1);
    rd(11'd7, 16'h807F);

    // Concurrent fill and drain streams.
    for (int i = 0; i < 16; i++) wr(AB'(i), pat_a(i));
    swap(1'b0);
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_acc   = 1'b0;
      wr_addr  = AB'(i);
      wr_data  = pat_b(i);
      rd_en    = 1'b1;
      rd_addr  = AB'(i);
      exp_q.push_back(pat_a(i));
      step();
      chk1("stream_wr_ready", wr_ready, 1'b1);
    end
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    step();
    swap(1'b1);
    for (int i = 0; i < 16; i++) rd(AB'(i), pat_b(i));
    step();

    // Swap requested together with an accumulate: deferred past the writeback.
    wr(11'd9, 16'h0201);
    wr_valid = 1'b1;
    wr_acc   = 1'b1;
    wr_addr  = 11'd9;
    wr_data  = 16'h0404;
    swap_req = 1'b1;
    step();
    wr_valid = 1'b0;
    wr_acc   = 1'b0;
    chk1("swap_defer_hs_ack", swap_ack, 1'b0);
    chk1("swap_defer_hs_fill", fill_sel, 1'b1);
    chk1("swap_defer_hs_busy", busy, 1'b1);
    step();
    chk1("swap_defer_wb_ack", swap_ack, 1'b0);
    chk1("swap_defer_wb_fill", fill_sel, 1'b1);
    step();
    swap_req = 1'b0;
    chk1("swap_after_wb_ack", swap_ack, 1'b1);
    chk1("swap_after_wb_fill", fill_sel, 1'b0);
    rd(11'd9, 16'h0605);

    // Reset during ACC_WB abandons the writeback and an in-flight read.
    swap(1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("rst2_fill_sel", fill_sel, 1'b0);
    wr(11'd3, 16'h0303);
    wr_valid = 1'b1;
    wr_acc   = 1'b1;
    wr_addr  = 11'd3;
    wr_data  = 16'h0707;
    step();
    chk1("rst3_in_acc_busy", busy, 1'b1);
    wr_valid = 1'b0;
    wr_acc   = 1'b0;
    rst      = 1'b1;
    rd_en    = 1'b1;
    rd_addr  = 11'd9;
    step();
    rst   = 1'b0;
    rd_en = 1'b0;
    chk1("rst3_rd_valid", rd_valid, 1'b0);
    chk1("rst3_fill_sel", fill_sel, 1'b0);
    chk1("rst3_busy", busy, 1'b0);
    chk1("rst3_wr_ready", wr_ready, 1'b1);
    swap(1'b1);
    rd(11'd3, 16'h0303);

    step();
    step();
    chk("scoreboard_empty", 16'(exp_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
